// File: rtl/accum_mc.sv
// accum_mc: NUM_CH independent accumulators sharing one addend port.
// Wrap or saturate per cycle, per-channel clear and sticky carry flags.
module accum_mc #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 sat,
    input  logic [CH_W-1:0]      ch_sel,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic [CH_W-1:0]      rd_sel,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]    ovf
);

    logic [OUT_WIDTH-1:0] acc_q [NUM_CH];
    logic [OUT_WIDTH-1:0] acc_d [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;
    logic [NUM_CH-1:0]    ovf_d;
    logic [NUM_CH-1:0]    hit;
    logic [OUT_WIDTH-1:0] cur;
    logic [OUT_WIDTH:0]   sum;
    logic [OUT_WIDTH-1:0] nxt;
    logic                 carry;

    // One-hot channel decode; an out-of-range ch_sel matches nothing.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (ch_sel == CH_W'(i));
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                cur = acc_q[i];
            end
        end
    end

    always_comb begin
        sum   = {1'b0, cur}
              + {{(OUT_WIDTH + 1 - IN_WIDTH){1'b0}}, data_in};
        carry = sum[OUT_WIDTH];
        nxt   = (sat && carry) ? '1 : sum[OUT_WIDTH-1:0];
    end

    // Clear outranks accumulate on the selected channel.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            if (hit[i]) begin
                if (clr) begin
                    acc_d[i] = '0;
                    ovf_d[i] = 1'b0;
                end else if (en) begin
                    acc_d[i] = nxt;
                    if (carry) begin
                        ovf_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == CH_W'(i)) begin
                data_out = acc_q[i];
            end
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_accum_mc.sv
// Directed and random checks of accum_mc in three shapes:
// 16-bit x4 (a), 10-bit x4 (b), 16-bit x3 (c), all on shared inputs.
module tb_accum_mc;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        sat;
    logic [1:0]  ch_sel;
    logic [7:0]  data_in;
    logic [1:0]  rd_sel;
    logic [15:0] dout_a;
    logic [9:0]  dout_b;
    logic [15:0] dout_c;
    logic [3:0]  ovf_a;
    logic [3:0]  ovf_b;
    logic [2:0]  ovf_c;

    int checks = 0;
    int errors = 0;

    int ma [4];
    int mb [4];
    int mc [3];
    bit oa [4];
    bit ob [4];
    bit oc [3];

    accum_mc #(.IN_WIDTH(8), .OUT_WIDTH(16), .NUM_CH(4)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sat(sat),
        .ch_sel(ch_sel), .data_in(data_in), .rd_sel(rd_sel),
        .data_out(dout_a), .ovf(ovf_a)
    );

    accum_mc #(.IN_WIDTH(8), .OUT_WIDTH(10), .NUM_CH(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sat(sat),
        .ch_sel(ch_sel), .data_in(data_in), .rd_sel(rd_sel),
        .data_out(dout_b), .ovf(ovf_b)
    );

    accum_mc #(.IN_WIDTH(8), .OUT_WIDTH(16), .NUM_CH(3)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sat(sat),
        .ch_sel(ch_sel), .data_in(data_in), .rd_sel(rd_sel),
        .data_out(dout_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic c, input logic s,
                       input logic [1:0] ch, input logic [7:0] d);
        en = e;
        clr = c;
        sat = s;
        ch_sel = ch;
        data_in = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h55);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h55);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            checks++;
            if (dout_a !== 16'h0 || dout_b !== 10'h0 || dout_c !== 16'h0) begin
                errors++;
                $display("FAIL reset_rd%0d got a=%h b=%h c=%h exp 0", i, dout_a, dout_b, dout_c);
            end
        end
        checks++;
        if (ovf_a !== 4'b0 || ovf_b !== 4'b0 || ovf_c !== 3'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b %b %b exp 0", ovf_a, ovf_b, ovf_c);
        end
    endtask

    task automatic test_independent();
        logic [15:0] exp_v [4];
        exp_v = '{16'h0, 16'h30, 16'h5, 16'h0};
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'h10);
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h05);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            checks++;
            if (dout_a !== exp_v[i] || dout_b !== exp_v[i][9:0]) begin
                errors++;
                $display("FAIL indep_ch%0d got a=%h b=%h exp %h", i, dout_a, dout_b, exp_v[i]);
            end
        end
        rd_sel = 2'd1;
        #1;
        checks++;
        if (dout_c !== 16'h30) begin
            errors++;
            $display("FAIL indep_c_ch1 got %h exp 0030", dout_c);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'hFF);
        rd_sel = 2'd0;
        #1;
        checks++;
        if (dout_b !== 10'h3FC || ovf_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pre got %h ovf %b exp 3fc 0", dout_b, ovf_b[0]);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h08);
        checks++;
        if (dout_b !== 10'h004 || ovf_b !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_carry got %h ovf %b exp 004 0001", dout_b, ovf_b);
        end
        checks++;
        if (dout_a !== 16'h0404 || ovf_a !== 4'b0) begin
            errors++;
            $display("FAIL wrap_wide got %h ovf %b exp 0404 0000", dout_a, ovf_a);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        checks++;
        if (dout_b !== 10'h005 || ovf_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sticky got %h ovf %b exp 005 1", dout_b, ovf_b[0]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'hFF);
        rd_sel = 2'd3;
        #1;
        checks++;
        if (dout_b !== 10'h3FC || ovf_b !== 4'b0) begin
            errors++;
            $display("FAIL sat_pre got %h ovf %b exp 3fc 0000", dout_b, ovf_b);
        end
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'h08);
        checks++;
        if (dout_b !== 10'h3FF || ovf_b !== 4'b1000) begin
            errors++;
            $display("FAIL sat_clip got %h ovf %b exp 3ff 1000", dout_b, ovf_b);
        end
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'h01);
        checks++;
        if (dout_b !== 10'h3FF) begin
            errors++;
            $display("FAIL sat_hold got %h exp 3ff", dout_b);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h01);
        checks++;
        if (dout_b !== 10'h000 || ovf_b[3] !== 1'b1) begin
            errors++;
            $display("FAIL sat_to_wrap got %h ovf %b exp 000 1", dout_b, ovf_b[3]);
        end
        checks++;
        if (dout_a !== 16'h0406 || dout_c !== 16'h0 || ovf_c !== 3'b0) begin
            errors++;
            $display("FAIL sat_others got a=%h c=%h ovfc=%b exp 0406 0 0", dout_a, dout_c, ovf_c);
        end
    endtask

    task automatic test_clear_priority();
        logic [9:0] exp_v [4];
        exp_v = '{10'h7, 10'h0, 10'h9, 10'h0};
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'h34);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h07);
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h09);
        rd_sel = 2'd1;
        #1;
        checks++;
        if (dout_b !== 10'h030 || ovf_b !== 4'b0010) begin
            errors++;
            $display("FAIL clr_pre got %h ovf %b exp 030 0010", dout_b, ovf_b);
        end
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            checks++;
            if (dout_b !== exp_v[i]) begin
                errors++;
                $display("FAIL clr_ch%0d got %h exp %h", i, dout_b, exp_v[i]);
            end
        end
        rd_sel = 2'd1;
        #1;
        checks++;
        if (ovf_b !== 4'b0 || dout_a !== 16'h0) begin
            errors++;
            $display("FAIL clr_flag got ovf %b a=%h exp 0000 0", ovf_b, dout_a);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp_v [4];
        exp_v = '{16'h11, 16'h0, 16'h22, 16'h0};
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h11);
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h22);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h40);
        rd_sel = 2'd3;
        #1;
        checks++;
        if (dout_a !== 16'h40 || dout_c !== 16'h0) begin
            errors++;
            $display("FAIL oor_en got a=%h c=%h exp 0040 0000", dout_a, dout_c);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            checks++;
            if (dout_c !== exp_v[i]) begin
                errors++;
                $display("FAIL oor_ch%0d got %h exp %h", i, dout_c, exp_v[i]);
            end
        end
        checks++;
        if (dout_a !== 16'h0 || ovf_c !== 3'b0) begin
            errors++;
            $display("FAIL oor_clr got a=%h ovfc=%b exp 0 000", dout_a, ovf_c);
        end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h05);
        cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'h06);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h10);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            checks++;
            if (dout_a !== 16'h0 || dout_b !== 10'h0) begin
                errors++;
                $display("FAIL rstmid_ch%0d got a=%h b=%h exp 0", i, dout_a, dout_b);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h03);
        rd_sel = 2'd0;
        #1;
        checks++;
        if (dout_a !== 16'h3) begin
            errors++;
            $display("FAIL rstmid_after got %h exp 0003", dout_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [4];
        exp_v = '{16'd1, 16'd3, 16'd6, 16'd10};
        do_reset();
        rd_sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'(i + 1));
            checks++;
            if (dout_a !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b_step%0d got %h exp %h", i, dout_a, exp_v[i]);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h21);
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h01);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        checks++;
        if (dout_a !== 16'd11) begin
            errors++;
            $display("FAIL b2b_mix got %h exp 000b", dout_a);
        end
    endtask

    function automatic int madd(input int a, input int d, input int w,
                                input bit s, output bit cy);
        int t;
        t = a + d;
        cy = (t >= (1 << w));
        if (cy && s) return (1 << w) - 1;
        return t % (1 << w);
    endfunction

    task automatic mstep(input bit e, input bit c, input bit s,
                         input bit r, input int ch, input int d);
        bit cy;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                ma[i] = 0; mb[i] = 0; oa[i] = 0; ob[i] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                mc[i] = 0; oc[i] = 0;
            end
        end else if (c) begin
            ma[ch] = 0; oa[ch] = 0;
            mb[ch] = 0; ob[ch] = 0;
            if (ch < 3) begin
                mc[ch] = 0; oc[ch] = 0;
            end
        end else if (e) begin
            ma[ch] = madd(ma[ch], d, 16, s, cy);
            if (cy) oa[ch] = 1;
            mb[ch] = madd(mb[ch], d, 10, s, cy);
            if (cy) ob[ch] = 1;
            if (ch < 3) begin
                mc[ch] = madd(mc[ch], d, 16, s, cy);
                if (cy) oc[ch] = 1;
            end
        end
    endtask

    task automatic test_soak();
        bit e, c, s, r;
        int ch, d, ds, ec;
        logic [3:0] xa, xb;
        logic [2:0] xc;
        do_reset();
        mstep(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        for (int n = 0; n < 10000; n++) begin
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            s = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 499) == 0);
            ch = $urandom_range(0, 3);
            ds = $urandom_range(0, 3);
            d = (ds == 0) ? 255 : (ds == 1) ? 0 : $urandom_range(0, 255);
            rst = r;
            cyc(e, c, s, 2'(ch), 8'(d));
            rst = 1'b0;
            mstep(e, c, s, r, ch, d);
            for (int i = 0; i < 4; i++) begin
                rd_sel = 2'(i);
                #1;
                ec = (i < 3) ? mc[i] : 0;
                checks++;
                if (32'(dout_a) !== ma[i] || 32'(dout_b) !== mb[i]
                    || 32'(dout_c) !== ec) begin
                    errors++;
                    $display("FAIL soak_n%0d_ch%0d got a=%h b=%h c=%h exp %h %h %h",
                             n, i, dout_a, dout_b, dout_c, ma[i], mb[i], ec);
                end
            end
            for (int i = 0; i < 4; i++) begin
                xa[i] = oa[i];
                xb[i] = ob[i];
            end
            for (int i = 0; i < 3; i++) xc[i] = oc[i];
            checks++;
            if (ovf_a !== xa || ovf_b !== xb || ovf_c !== xc) begin
                errors++;
                $display("FAIL soak_ovf_n%0d got %b %b %b exp %b %b %b",
                         n, ovf_a, ovf_b, ovf_c, xa, xb, xc);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        sat = 1'b0;
        ch_sel = 2'd0;
        data_in = 8'h0;
        rd_sel = 2'd0;
        test_reset();
        test_independent();
        test_wrap();
        test_saturate();
        test_clear_priority();
        test_out_of_range();
        test_rst_midstream();
        test_back_to_back();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
